window_3x3_generator: RTL and testbench



---
 rtl/window_3x3_generator_if.sv | 26 ++
 rtl/window_3x3_generator.sv | 209 ++++++++++++++++++++
 tb/tb_window_3x3_generator.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_3x3_generator_if.sv
// Stream interface for window_3x3_generator.
//   in_pixel/in_valid/in_ready : raster-order pixel input with ready/valid handshake
//   w1..w9                     : 3x3 window, raster order, w5 is the centre pixel
//   out_valid                  : one-cycle pulse, w1..w9 hold a new window
//   frame_done                 : one-cycle pulse with the last window of a frame
// master = pixel source / window consumer, slave = the window generator.
interface window_3x3_generator_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] in_pixel;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
   logic              out_valid;
   logic              frame_done;

   modport master (
      output in_pixel, in_valid,
      input  in_ready, w1, w2, w3, w4, w5, w6, w7, w8, w9, out_valid, frame_done
   );

   modport slave (
      input  in_pixel, in_valid,
      output in_ready, w1, w2, w3, w4, w5, w6, w7, w8, w9, out_valid, frame_done
   );
endinterface

// File: rtl/window_3x3_generator.sv
// Streaming 3x3 neighbourhood generator.
// Takes one raster-order pixel per accepted handshake and emits one registered 3x3 window per
// image pixel, with replicate-border clamping at all four image edges.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of window_3x3_generator_if (pixel in, window out)
// The window centred on input idx k is emitted the cycle after idx k+IMG_WIDTH+1 is accepted;
// the trailing IMG_WIDTH+1 windows are flushed one per cycle with in_ready low.
module window_3x3_generator #(
   parameter int unsigned IMG_WIDTH  = 512,
   parameter int unsigned IMG_HEIGHT = 512,
   parameter int unsigned DATA_W     = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   window_3x3_generator_if.slave bus
);

   localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      StFill,
      StRun,
      StFlush
   } state_e;

   state_e state_q, state_d;

   // Input (write) position and centre (emitted window) position.
   logic [COL_W-1:0] in_col_q, in_col_d;
   logic [ROW_W-1:0] in_row_q, in_row_d;
   logic [COL_W-1:0] cen_col_q, cen_col_d;
   logic [ROW_W-1:0] cen_row_q, cen_row_d;

   // lb_mid holds the previous input row, lb_top the one before it.
   logic [DATA_W-1:0] lb_top [IMG_WIDTH];
   logic [DATA_W-1:0] lb_mid [IMG_WIDTH];

   // Column shift register, index 0 = top, 1 = mid, 2 = bottom.
   // cur_col is the centre column of the next window, prv_col its left neighbour,
   // new_col (line buffers + incoming pixel) its right neighbour.
   logic [DATA_W-1:0] prv_col [3];
   logic [DATA_W-1:0] cur_col [3];
   logic [DATA_W-1:0] new_col [3];

   logic [DATA_W-1:0] sel_col [3][3];
   logic [DATA_W-1:0] win_d   [9];
   logic [DATA_W-1:0] win_q   [9];

   logic out_valid_q, frame_done_q, frame_done_d;
   logic in_ready, flushing, accept, emit, shift;
   logic at_left, at_right, at_top, at_bottom;

   assign flushing = (state_q == StFlush);
   assign in_ready = !flushing;
   assign accept   = bus.in_valid && in_ready;
   assign emit     = ((state_q == StRun) && accept) || flushing;
   // During flush the column pipe keeps advancing over the line buffers; the garbage bottom
   // row it picks up is always clamped away because the centre is then on the last row.
   assign shift    = accept || flushing;

   assign at_left   = (cen_col_q == '0);
   assign at_right  = (cen_col_q == COL_LAST);
   assign at_top    = (cen_row_q == '0);
   assign at_bottom = (cen_row_q == ROW_LAST);

   always_comb begin
      new_col[0] = lb_top[in_col_q];
      new_col[1] = lb_mid[in_col_q];
      new_col[2] = bus.in_pixel;
   end

   // Border clamp: pick columns first, then rows, both from the centre counters.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         sel_col[0][i] = at_left  ? cur_col[i] : prv_col[i];
         sel_col[1][i] = cur_col[i];
         sel_col[2][i] = at_right ? cur_col[i] : new_col[i];
      end
      for (int x = 0; x < 3; x++) begin
         win_d[x]     = at_top    ? sel_col[x][1] : sel_col[x][0];
         win_d[3 + x] = sel_col[x][1];
         win_d[6 + x] = at_bottom ? sel_col[x][1] : sel_col[x][2];
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d      = state_q;
      in_col_d     = in_col_q;
      in_row_d     = in_row_q;
      cen_col_d    = cen_col_q;
      cen_row_d    = cen_row_q;
      frame_done_d = 1'b0;

      if (accept) begin
         if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = in_row_q + ROW_W'(1);
         end else begin
            in_col_d = in_col_q + COL_W'(1);
         end
      end

      if (emit) begin
         if (at_right) begin
            cen_col_d = '0;
            cen_row_d = cen_row_q + ROW_W'(1);
         end else begin
            cen_col_d = cen_col_q + COL_W'(1);
         end
      end

      unique case (state_q)
         StFill: begin
            // Idx IMG_WIDTH is position (1,0): once it is in, the (0,0) window is complete
            // except for its right neighbour, which arrives with the next accept.
            if (accept && (in_row_q == ROW_W'(1)) && (in_col_q == '0)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (accept && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST)) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            // Only the column index matters here, it addresses the line buffers.
            in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + COL_W'(1);
            in_row_d = in_row_q;
            if (at_right && at_bottom) begin
               frame_done_d = 1'b1;
               state_d      = StFill;
               in_col_d     = '0;
               in_row_d     = '0;
               cen_col_d    = '0;
               cen_row_d    = '0;
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StFill;
         in_col_q     <= '0;
         in_row_q     <= '0;
         cen_col_q    <= '0;
         cen_row_q    <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            prv_col[i] <= '0;
            cur_col[i] <= '0;
         end
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         in_col_q     <= in_col_d;
         in_row_q     <= in_row_d;
         cen_col_q    <= cen_col_d;
         cen_row_q    <= cen_row_d;
         out_valid_q  <= emit;
         frame_done_q <= frame_done_d;
         if (shift) begin
            for (int i = 0; i < 3; i++) begin
               prv_col[i] <= cur_col[i];
               cur_col[i] <= new_col[i];
            end
         end
         if (emit) begin
            for (int i = 0; i < 9; i++) begin
               win_q[i] <= win_d[i];
            end
         end
      end
   end

   // Line buffers carry no reset; stale rows are always masked by the top-border clamp.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_top[in_col_q] <= lb_mid[in_col_q];
         lb_mid[in_col_q] <= bus.in_pixel;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.w1         = win_q[0];
   assign bus.w2         = win_q[1];
   assign bus.w3         = win_q[2];
   assign bus.w4         = win_q[3];
   assign bus.w5         = win_q[4];
   assign bus.w6         = win_q[5];
   assign bus.w7         = win_q[6];
   assign bus.w8         = win_q[7];
   assign bus.w9         = win_q[8];

endmodule

// File: tb/tb_window_3x3_generator.sv
module tb_window_3x3_generator;
   localparam int unsigned DW = 8;
   localparam int AW = 4;
   localparam int AH = 4;
   localparam int BW = 5;
   localparam int BH = 3;

   typedef logic [9*DW-1:0] win_t;
   typedef logic [79:0]     val_t;
   typedef struct packed {
      win_t win;
      logic done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   window_3x3_generator_if #(.DATA_W(DW)) a_if ();
   window_3x3_generator_if #(.DATA_W(DW)) b_if ();

   window_3x3_generator #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .DATA_W(DW)) dut_a (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (a_if.slave)
   );

   window_3x3_generator #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_W(DW)) dut_b (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b_if.slave)
   );

   win_t a_win, b_win;
   assign a_win = {a_if.w1, a_if.w2, a_if.w3, a_if.w4, a_if.w5, a_if.w6, a_if.w7, a_if.w8, a_if.w9};
   assign b_win = {b_if.w1, b_if.w2, b_if.w3, b_if.w4, b_if.w5, b_if.w6, b_if.w7, b_if.w8, b_if.w9};

   int n_chk = 0;
   int n_bad = 0;

   exp_t qa[$];
   exp_t qb[$];
   int   img [0:63];
   win_t cap_a [0:15];
   win_t cap_b [0:31];
   int   pulses_a = 0;
   int   pulses_b = 0;

   task automatic check(input string name, input val_t got, input val_t want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Reference window straight from clamped image coordinates.
   function automatic win_t model(input int w, input int h, input int r, input int c);
      win_t res;
      int   rr;
      int   cc;
      res = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr  = clampi(r + dr, h - 1);
            cc  = clampi(c + dc, w - 1);
            res = (res << DW) | win_t'(img[rr*w + cc] & 8'hff);
         end
      end
      return res;
   endfunction

   task automatic push_frame(input int which, input int w, input int h);
      exp_t e;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            e.win  = model(w, h, r, c);
            e.done = (r == h - 1) && (c == w - 1);
            if (which == 0) qa.push_back(e);
            else qb.push_back(e);
         end
      end
   endtask

   // Drive one pixel until accepted; inputs change 1 time unit after posedge.
   task automatic send(input int which, input int v, input bit gaps);
      int guard;
      bit ok;
      guard = 0;
      ok    = 1'b0;
      if (gaps) begin
         for (int i = 0; i < 3 && $urandom_range(0, 1) == 1; i++) begin
            @(posedge clk);
            #1;
         end
      end
      if (which == 0) begin
         a_if.in_valid = 1'b1;
         a_if.in_pixel = DW'(v);
      end else begin
         b_if.in_valid = 1'b1;
         b_if.in_pixel = DW'(v);
      end
      do begin
         @(negedge clk);
         ok = (which == 0) ? a_if.in_ready : b_if.in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!ok && guard < 100);
      if (!ok) begin
         n_chk++;
         n_bad++;
         $display("FAIL accept timeout: got in_ready=0 want 1 within 100 cycles");
      end
      a_if.in_valid = 1'b0;
      b_if.in_valid = 1'b0;
   endtask

   task automatic drain(input int which);
      int sz;
      for (int i = 0; i < 200; i++) begin
         sz = (which == 0) ? qa.size() : qb.size();
         if (sz == 0) break;
         @(posedge clk);
      end
      repeat (2) @(posedge clk);
      #1;
      sz = (which == 0) ? qa.size() : qb.size();
      n_chk++;
      if (sz != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d windows outstanding want 0", sz);
      end
   endtask

   // Monitor A: scoreboard, handshake timing model and hold check.
   int   idx_a = 0;
   int   flush_a = 0;
   bit   exp_ov_a = 1'b0;
   int   wcnt_a = 0;
   win_t last_a = '0;
   exp_t ea;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("a reset out_valid", val_t'(a_if.out_valid), val_t'(0));
         check("a reset in_ready", val_t'(a_if.in_ready), val_t'(1));
         idx_a    = 0;
         flush_a  = 0;
         exp_ov_a = 1'b0;
         wcnt_a   = 0;
         last_a   = '0;
      end else begin
         check("a out_valid timing", val_t'(a_if.out_valid), val_t'(exp_ov_a));
         if (a_if.out_valid) begin
            pulses_a++;
            if (qa.size() == 0) begin
               n_chk++;
               n_bad++;
               $display("FAIL a unexpected window: got %0h want none", a_win);
            end else begin
               ea = qa.pop_front();
               check("a window", val_t'(a_win), val_t'(ea.win));
               check("a frame_done", val_t'(a_if.frame_done), val_t'(ea.done));
            end
            if (wcnt_a < 16) cap_a[wcnt_a] = a_win;
            wcnt_a = a_if.frame_done ? 0 : wcnt_a + 1;
            last_a = a_win;
         end else begin
            check("a hold", val_t'(a_win), val_t'(last_a));
            check("a frame_done idle", val_t'(a_if.frame_done), val_t'(0));
         end
         if (flush_a > 0) begin
            check("a in_ready flush", val_t'(a_if.in_ready), val_t'(0));
            exp_ov_a = 1'b1;
            flush_a--;
         end else begin
            check("a in_ready", val_t'(a_if.in_ready), val_t'(1));
            exp_ov_a = a_if.in_valid && (idx_a >= AW + 1);
            if (a_if.in_valid) begin
               idx_a++;
               if (idx_a == AW*AH) begin
                  idx_a   = 0;
                  flush_a = AW + 1;
               end
            end
         end
      end
   end

   // Monitor B: scoreboard and hold check.
   int   wcnt_b = 0;
   win_t last_b = '0;
   exp_t eb;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("b reset out_valid", val_t'(b_if.out_valid), val_t'(0));
         wcnt_b = 0;
         last_b = '0;
      end else if (b_if.out_valid) begin
         pulses_b++;
         if (qb.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL b unexpected window: got %0h want none", b_win);
         end else begin
            eb = qb.pop_front();
            check("b window", val_t'(b_win), val_t'(eb.win));
            check("b frame_done", val_t'(b_if.frame_done), val_t'(eb.done));
         end
         if (wcnt_b < 32) cap_b[wcnt_b] = b_win;
         wcnt_b++;
         last_b = b_win;
      end else begin
         check("b hold", val_t'(b_win), val_t'(last_b));
      end
   end

   task automatic load_ramp_a();
      for (int r = 0; r < AH; r++)
         for (int c = 0; c < AW; c++) img[r*AW + c] = 16*r + c;
   endtask

   task automatic run_frame_a(input bit gaps);
      load_ramp_a();
      push_frame(0, AW, AH);
      pulses_a = 0;
      for (int k = 0; k < AW*AH; k++) send(0, 16*(k / AW) + (k % AW), gaps);
      drain(0);
   endtask

   task automatic check_ramp_caps(input string tag);
      check({tag, " win(0,0)"}, val_t'(cap_a[0]),  val_t'(72'h00_00_01_00_00_01_10_10_11));
      check({tag, " win(1,1)"}, val_t'(cap_a[5]),  val_t'(72'h00_01_02_10_11_12_20_21_22));
      check({tag, " win(0,3)"}, val_t'(cap_a[3]),  val_t'(72'h02_03_03_02_03_03_12_13_13));
      check({tag, " win(3,3)"}, val_t'(cap_a[15]), val_t'(72'h22_23_23_32_33_33_32_33_33));
      check({tag, " pulses"}, val_t'(pulses_a), val_t'(16));
   endtask

   initial begin
      a_if.in_valid = 1'b0;
      a_if.in_pixel = '0;
      b_if.in_valid = 1'b0;
      b_if.in_pixel = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset window", val_t'(a_win), val_t'(0));
      check("reset frame_done", val_t'(a_if.frame_done), val_t'(0));
      check("reset b window", val_t'(b_win), val_t'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Gap-free 4x4 ramp frame.
      run_frame_a(1'b0);
      check_ramp_caps("ramp");

      // Same frame with random input gaps.
      run_frame_a(1'b1);
      check_ramp_caps("gaps");

      // Reset after 9 accepts, then a fresh frame.
      load_ramp_a();
      push_frame(0, AW, AH);
      for (int k = 0; k < 9; k++) send(0, 16*(k / AW) + (k % AW), 1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      qa.delete();
      #1;
      rst_n = 1'b1;
      run_frame_a(1'b0);
      check_ramp_caps("post-reset");

      // Two back-to-back 5x3 frames, the second flat 0x80.
      for (int k = 0; k < BW*BH; k++) img[k] = k + 1;
      push_frame(1, BW, BH);
      for (int k = 0; k < BW*BH; k++) img[k] = 8'h80;
      push_frame(1, BW, BH);
      pulses_b = 0;
      for (int k = 0; k < BW*BH; k++) send(1, k + 1, 1'b0);
      for (int k = 0; k < BW*BH; k++) send(1, 8'h80, 1'b0);
      drain(1);
      check("b pulses", val_t'(pulses_b), val_t'(30));
      check("b frame1 win(0,0)", val_t'(cap_b[0]), val_t'(72'h01_01_02_01_01_02_06_06_07));
      check("b frame2 first", val_t'(cap_b[15]), val_t'({9{8'h80}}));
      check("b frame2 last", val_t'(cap_b[29]), val_t'({9{8'h80}}));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish before 300000");
      $fatal(1, "watchdog expired");
   end

endmodule
